// File: rtl/bios_upload_if.sv
// Fetch-side memory bus and IO-controller upload port of bios_upload.
// master = the uploader, slave = the memory / IO controller side.
interface bios_upload_if;
  logic [13:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [15:0] mem_din;
  logic        ioctl_upload;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_rd;

  modport master (
    output mem_addr, mem_req, ioctl_upload, ioctl_addr, ioctl_din,
    input  mem_ack, mem_din, ioctl_rd
  );

  modport slave (
    input  mem_addr, mem_req, ioctl_upload, ioctl_addr, ioctl_din,
    output mem_ack, mem_din, ioctl_rd
  );
endinterface

// File: rtl/bios_upload.sv
// Streams word_count 16-bit words from memory to the IO controller as bytes,
// low byte first, through a circular word buffer of BUF_WORDS entries.
module bios_upload #(
  parameter int BUF_WORDS = 64
) (
  input  logic         clk_sdr,
  input  logic         reset,
  input  logic         start,
  input  logic [13:0]  word_count,
  output logic         busy,
  output logic         done,
  output logic         underrun,
  bios_upload_if.master bus
);

  localparam int PTR_W = $clog2(BUF_WORDS);
  localparam int OCC_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  logic [15:0] buf_mem [BUF_WORDS];

  logic [1:0]       state_reg,      state_next;
  logic [14:0]      count_reg,      count_next;
  logic [14:0]      fetched_reg,    fetched_next;
  logic [13:0]      mem_addr_reg,   mem_addr_next;
  logic [PTR_W-1:0] wr_ptr_reg,     wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg,     rd_ptr_next;
  logic [OCC_W-1:0] occ_reg,        occ_next;
  logic [24:0]      ioctl_addr_reg, ioctl_addr_next;
  logic [7:0]       ioctl_din_reg,  ioctl_din_next;
  logic             underrun_reg,   underrun_next;

  logic        mem_req_w;
  logic        ack_take;
  logic        rd_take;
  logic        rd_starve;
  logic        word_free;
  logic        last_byte;
  logic [14:0] fetched_inc;
  logic [24:0] last_addr;
  logic [15:0] head_word;

  assign mem_req_w   = (state_reg == ST_RUN) && (fetched_reg < count_reg)
                       && (occ_reg < OCC_W'(BUF_WORDS));
  assign ack_take    = mem_req_w && bus.mem_ack;
  assign rd_take     = (state_reg == ST_RUN) && bus.ioctl_rd && (occ_reg != '0);
  assign rd_starve   = (state_reg == ST_RUN) && bus.ioctl_rd && (occ_reg == '0);
  assign word_free   = rd_take && ioctl_addr_reg[0];
  assign last_addr   = {9'd0, count_reg, 1'b0} - 25'd1;
  assign last_byte   = rd_take && (ioctl_addr_reg == last_addr);
  assign fetched_inc = fetched_reg + 15'd1;

  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg;
    fetched_next    = fetched_reg;
    mem_addr_next   = mem_addr_reg;
    wr_ptr_next     = wr_ptr_reg;
    rd_ptr_next     = rd_ptr_reg;
    occ_next        = occ_reg;
    ioctl_addr_next = ioctl_addr_reg;
    underrun_next   = underrun_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next      = ST_RUN;
          count_next      = (word_count == 14'd0) ? 15'd16384 : {1'b0, word_count};
          fetched_next    = '0;
          mem_addr_next   = '0;
          wr_ptr_next     = '0;
          rd_ptr_next     = '0;
          occ_next        = '0;
          ioctl_addr_next = '0;
          underrun_next   = 1'b0;
        end
      end
      ST_RUN: begin
        if (ack_take) begin
          wr_ptr_next  = wr_ptr_reg + PTR_W'(1);
          fetched_next = fetched_inc;
          // The address parks on the final word instead of running past it.
          if (fetched_inc < count_reg)
            mem_addr_next = mem_addr_reg + 14'd1;
        end
        if (rd_take)
          ioctl_addr_next = ioctl_addr_reg + 25'd1;
        if (word_free)
          rd_ptr_next = rd_ptr_reg + PTR_W'(1);
        occ_next = occ_reg + OCC_W'(ack_take) - OCC_W'(word_free);
        if (rd_starve)
          underrun_next = 1'b1;
        if (last_byte)
          state_next = ST_FINISH;
      end
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // A word written this cycle at the next read slot is forwarded straight
  // from mem_din so the byte shows up the cycle after the write.
  always_comb begin
    head_word = buf_mem[rd_ptr_next];
    if (ack_take && (wr_ptr_reg == rd_ptr_next))
      head_word = bus.mem_din;
    if (occ_next == '0)
      ioctl_din_next = 8'hFF;
    else if (ioctl_addr_next[0])
      ioctl_din_next = head_word[15:8];
    else
      ioctl_din_next = head_word[7:0];
  end

  always_ff @(posedge clk_sdr) begin
    if (ack_take)
      buf_mem[wr_ptr_reg] <= bus.mem_din;
  end

  always_ff @(posedge clk_sdr) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      count_reg      <= '0;
      fetched_reg    <= '0;
      mem_addr_reg   <= '0;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      occ_reg        <= '0;
      ioctl_addr_reg <= '0;
      ioctl_din_reg  <= 8'hFF;
      underrun_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      fetched_reg    <= fetched_next;
      mem_addr_reg   <= mem_addr_next;
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      occ_reg        <= occ_next;
      ioctl_addr_reg <= ioctl_addr_next;
      ioctl_din_reg  <= ioctl_din_next;
      underrun_reg   <= underrun_next;
    end
  end

  assign busy             = (state_reg != ST_IDLE);
  assign done             = (state_reg == ST_FINISH);
  assign underrun         = underrun_reg;
  assign bus.mem_addr     = mem_addr_reg;
  assign bus.mem_req      = mem_req_w;
  assign bus.ioctl_upload = (state_reg == ST_RUN);
  assign bus.ioctl_addr   = ioctl_addr_reg;
  assign bus.ioctl_din    = ioctl_din_reg;

endmodule

// File: tb/tb_bios_upload.sv
// Randomized bench for bios_upload: a byte-stream model built from a word
// memory image predicts every cycle of the fetch and IO-controller ports.
module tb_bios_upload;
  localparam int BUF = 64;

  logic        clk_sdr = 1'b0;
  logic        reset;
  logic        start;
  logic [13:0] word_count;
  logic        busy;
  logic        done;
  logic        underrun;

  bios_upload_if bus ();

  bios_upload #(.BUF_WORDS(BUF)) dut (
    .clk_sdr    (clk_sdr),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .underrun   (underrun),
    .bus        (bus)
  );

  always #5 clk_sdr = ~clk_sdr;

  int total = 0;
  int bad   = 0;
  logic [15:0] mem_data [16384];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int k);
    logic [15:0] w;
    w = mem_data[k / 2];
    return (k % 2 == 1) ? w[15:8] : w[7:0];
  endfunction

  task automatic check_idle(input string tag, input int exp_addr);
    check({tag, "_busy"},   busy, 0);
    check({tag, "_done"},   done, 0);
    check({tag, "_req"},    bus.mem_req, 0);
    check({tag, "_upload"}, bus.ioctl_upload, 0);
    check({tag, "_din"},    bus.ioctl_din, 8'hFF);
    check({tag, "_iaddr"},  bus.ioctl_addr, exp_addr);
  endtask

  // n words (16384 encoded as 0); acks/rds suppressed for the first *_hold
  // cycles; abort_byte >= 0 fires reset when that byte is being presented.
  task automatic upload(input int n, input int ack_pct, input int rd_pct,
                        input int ack_hold, input int rd_hold, input int abort_byte);
    int  acked = 0, consumed = 0, cyc = 0, stall = 0, occ, avail;
    bit  exp_ur = 0, exp_req, do_ack, do_rd;
    start      = 1'b1;
    word_count = 14'(n);
    @(negedge clk_sdr);
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_underrun", underrun, 0);
    check("start_maddr", bus.mem_addr, 0);
    check("start_iaddr", bus.ioctl_addr, 0);
    while (consumed < 2 * n) begin
      occ     = acked - consumed / 2;
      avail   = 2 * acked - consumed;
      exp_req = (acked < n) && (occ < BUF);
      check("mem_req", bus.mem_req, exp_req);
      check("mem_addr", bus.mem_addr, (acked < n) ? acked : n - 1);
      check("ioctl_addr", bus.ioctl_addr, consumed);
      check("ioctl_din", bus.ioctl_din, (avail > 0) ? exp_byte(consumed) : 8'hFF);
      check("ioctl_upload", bus.ioctl_upload, 1);
      check("busy", busy, 1);
      check("underrun", underrun, exp_ur);
      check("done_early", done, 0);
      if (abort_byte >= 0 && consumed == abort_byte) begin
        reset = 1'b1; start = 1'b1; bus.ioctl_rd = 1'b1; bus.mem_ack = 1'b1;
        @(negedge clk_sdr);
        reset = 1'b0; start = 1'b0; bus.ioctl_rd = 1'b0; bus.mem_ack = 1'b0;
        check_idle("abort", 0);
        check("abort_underrun", underrun, 0);
        check("abort_maddr", bus.mem_addr, 0);
        $display("upload n=%0d aborted by reset at byte %0d", n, consumed);
        return;
      end
      if (cyc >= 90000 || stall >= 2000) begin
        check("timeout_bytes", consumed, 2 * n);
        break;
      end
      do_ack       = (cyc >= ack_hold) && exp_req && ($urandom_range(99) < ack_pct);
      bus.mem_ack  = do_ack || (!exp_req && ($urandom_range(99) < 10));
      bus.mem_din  = do_ack ? mem_data[acked] : 16'($urandom);
      do_rd        = (cyc >= rd_hold) && ($urandom_range(99) < rd_pct);
      bus.ioctl_rd = do_rd;
      start        = ($urandom_range(99) < 3);
      word_count   = 14'($urandom);
      if (do_rd) begin
        if (avail > 0) consumed++;
        else exp_ur = 1'b1;
      end
      if (do_ack) acked++;
      if (do_rd && avail > 0) stall = 0;
      else if (cyc >= rd_hold && cyc >= ack_hold) stall++;
      cyc++;
      @(negedge clk_sdr);
    end
    start = 1'b0;
    check("fin_done", done, 1);
    check("fin_busy", busy, 1);
    check("fin_upload", bus.ioctl_upload, 0);
    check("fin_req", bus.mem_req, 0);
    check("fin_iaddr", bus.ioctl_addr, 2 * n);
    check("fin_underrun", underrun, exp_ur);
    bus.ioctl_rd = 1'b1;
    bus.mem_ack  = 1'b1;
    @(negedge clk_sdr);
    bus.ioctl_rd = 1'b0;
    bus.mem_ack  = 1'b0;
    check_idle("post", 2 * n);
    check("post_underrun", underrun, exp_ur);
    $display("upload n=%0d bytes=%0d underrun=%0b cycles=%0d", n, consumed, exp_ur, cyc);
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; word_count = 14'd5;
    bus.mem_ack = 1'b0; bus.mem_din = 16'h0; bus.ioctl_rd = 1'b0;
    for (int i = 0; i < 16384; i++) mem_data[i] = 16'($urandom);
    mem_data[0] = 16'h1234; mem_data[1] = 16'h5678;
    mem_data[2] = 16'hABCD; mem_data[3] = 16'hEF01;
    repeat (3) @(negedge clk_sdr);
    reset = 1'b0; start = 1'b0;
    check_idle("reset", 0);
    check("reset_underrun", underrun, 0);
    check("reset_maddr", bus.mem_addr, 0);
    @(negedge clk_sdr);
    check("reset_stays_idle", busy, 0);
    $display("reset released");

    upload(4, 100, 100, 0, 2, -1);
    upload(8, 100, 100, 3, 0, -1);
    upload(200, 100, 100, 0, 150, -1);
    upload(100, 70, 70, 0, 0, 37);
    upload(10, 80, 80, 0, 3, -1);
    for (int t = 0; t < 4; t++)
      upload($urandom_range(300, 1), $urandom_range(100, 20), $urandom_range(100, 20),
             $urandom_range(5), $urandom_range(5), -1);
    upload(16384, 70, 75, 0, 0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
